// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, functs,
// FSM state encodings, ALU control codes and datapath mux select codes.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALURESULT = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
    localparam logic [1:0] PCSRC_JUMP      = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQ     = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's 2-bit ALUOp plus the instruction funct field to an ALU
// control code, flagging functs the ALU does not support.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] aluOp_i,
    input  logic [5:0] funct_i,
    output logic [2:0] aluControl_o,
    output logic       functIllegal_o
);

    always_comb begin
        aluControl_o   = ALU_ADD;
        functIllegal_o = 1'b0;
        case (aluOp_i)
            ALUOP_SUB: aluControl_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FN_ADD:  aluControl_o = ALU_ADD;
                    FN_SUB:  aluControl_o = ALU_SUB;
                    FN_AND:  aluControl_o = ALU_AND;
                    FN_OR:   aluControl_o = ALU_OR;
                    FN_SLT:  aluControl_o = ALU_SLT;
                    default: functIllegal_o = 1'b1;
                endcase
            end
            default: aluControl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencing FSM for the multicycle MIPS datapath: steps through
// fetch/decode/execute states and drives every mux select and enable.
module multicycle_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCEn,
    output logic [1:0] PCSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    state_t     state_q, state_d;
    logic [1:0] aluOp;
    logic [2:0] aluCtrlDec;
    logic       functIllegal;
    logic       pcWrite;
    logic       branch;
    logic       aluForceZero;

    alu_decoder u_alu_decoder (
        .aluOp_i        (aluOp),
        .funct_i        (Funct),
        .aluControl_o   (aluCtrlDec),
        .functIllegal_o (functIllegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = S_FETCH;
        IorD         = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        PCSrc        = PCSRC_ALURESULT;
        ALUSrcA      = 1'b0;
        ALUSrcB      = SRCB_B;
        aluOp        = ALUOP_ADD;
        RegDst       = 1'b0;
        MemtoReg     = 1'b0;
        RegWrite     = 1'b0;
        instr_done   = 1'b0;
        illegal      = 1'b0;
        pcWrite      = 1'b0;
        branch       = 1'b0;
        aluForceZero = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRWrite = 1'b1;
                ALUSrcB = SRCB_FOUR;
                pcWrite = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SH2;
                case (Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                aluOp   = ALUOP_FUNCT;
                illegal = functIllegal;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA    = 1'b1;
                aluOp      = ALUOP_SUB;
                PCSrc      = PCSRC_ALUOUT;
                branch     = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                PCSrc      = PCSRC_JUMP;
                pcWrite    = 1'b1;
                instr_done = 1'b1;
            end
            // Encodings 12-15 are unreachable; silence everything including ALUControl.
            default: aluForceZero = 1'b1;
        endcase
    end

    assign ALUControl = aluForceZero ? 3'b000 : aluCtrlDec;
    assign PCEn       = pcWrite | (branch & zero);
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a per-cycle vector table of
// expected state and control outputs, plus reset and branch corner cases.
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       zero;
    logic       IorD, MemWrite, IRWrite, PCEn;
    logic [1:0] PCSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic       RegDst, MemtoReg, RegWrite, instr_done, illegal;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic [3:0]  st;
        logic [16:0] exp;
    } vec_t;

    vec_t vecs[$];

    logic [16:0] eFetch, eDecode, eDecodeIll, eMemAdr, eMemRd, eMemWb, eMemWr;
    logic [16:0] eAluWb, eBeq0, eBeq1, eAddiWb, eJump;
    logic [16:0] actBundle;

    assign actBundle = {IorD, MemWrite, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB,
                        ALUControl, RegDst, MemtoReg, RegWrite, instr_done, illegal};

    multicycle_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Opcode     (Opcode),
        .Funct      (Funct),
        .zero       (zero),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .PCEn       (PCEn),
        .PCSrc      (PCSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .instr_done (instr_done),
        .illegal    (illegal),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] pk(
        input logic iord, input logic memw, input logic irw, input logic pcen,
        input logic [1:0] pcsrc, input logic srca, input logic [1:0] srcb,
        input logic [2:0] aluc, input logic regdst, input logic memtoreg,
        input logic regw, input logic done, input logic ill);
        return {iord, memw, irw, pcen, pcsrc, srca, srcb, aluc,
                regdst, memtoreg, regw, done, ill};
    endfunction

    function automatic logic [16:0] eExec(input logic [2:0] aluc, input logic ill);
        return pk(0, 0, 0, 0, 2'b00, 1, 2'b00, aluc, 0, 0, 0, 0, ill);
    endfunction

    task automatic addVec(input logic [5:0] op, input logic [5:0] fn, input logic z,
                          input logic [3:0] st, input logic [16:0] exp);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.st = st; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic z);
        Opcode = op;
        Funct  = fn;
        zero   = z;
    endtask

    task automatic checkOutput(input string name, input logic [16:0] actual,
                               input logic [16:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic doReset(input logic [5:0] op);
        applyStimulus(op, 6'b100000, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        eFetch     = pk(0, 0, 1, 1, 2'b00, 0, 2'b01, 3'b010, 0, 0, 0, 0, 0);
        eDecode    = pk(0, 0, 0, 0, 2'b00, 0, 2'b11, 3'b010, 0, 0, 0, 0, 0);
        eDecodeIll = pk(0, 0, 0, 0, 2'b00, 0, 2'b11, 3'b010, 0, 0, 0, 1, 1);
        eMemAdr    = pk(0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b010, 0, 0, 0, 0, 0);
        eMemRd     = pk(1, 0, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0, 0, 0, 0, 0);
        eMemWb     = pk(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0, 1, 1, 1, 0);
        eMemWr     = pk(1, 1, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0, 0, 0, 1, 0);
        eAluWb     = pk(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b010, 1, 0, 1, 1, 0);
        eBeq0      = pk(0, 0, 0, 0, 2'b01, 1, 2'b00, 3'b110, 0, 0, 0, 1, 0);
        eBeq1      = pk(0, 0, 0, 1, 2'b01, 1, 2'b00, 3'b110, 0, 0, 0, 1, 0);
        eAddiWb    = pk(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0, 0, 1, 1, 0);
        eJump      = pk(0, 0, 0, 1, 2'b10, 0, 2'b00, 3'b010, 0, 0, 0, 1, 0);

        // lw: 5 cycles, zero toggling outside BEQ must not move PCEn
        addVec(6'b100011, 6'b000000, 0, 4'd0, eFetch);
        addVec(6'b100011, 6'b000000, 1, 4'd1, eDecode);
        addVec(6'b100011, 6'b000000, 0, 4'd2, eMemAdr);
        addVec(6'b100011, 6'b000000, 1, 4'd3, eMemRd);
        addVec(6'b100011, 6'b000000, 0, 4'd4, eMemWb);
        // sw: 4 cycles
        addVec(6'b101011, 6'b000000, 0, 4'd0, eFetch);
        addVec(6'b101011, 6'b000000, 0, 4'd1, eDecode);
        addVec(6'b101011, 6'b000000, 0, 4'd2, eMemAdr);
        addVec(6'b101011, 6'b000000, 1, 4'd5, eMemWr);
        // R-type sub, slt, and, or, then an unsupported funct
        addVec(6'b000000, 6'b100010, 0, 4'd0, eFetch);
        addVec(6'b000000, 6'b100010, 0, 4'd1, eDecode);
        addVec(6'b000000, 6'b100010, 0, 4'd6, eExec(3'b110, 0));
        addVec(6'b000000, 6'b100010, 0, 4'd7, eAluWb);
        addVec(6'b000000, 6'b101010, 0, 4'd0, eFetch);
        addVec(6'b000000, 6'b101010, 0, 4'd1, eDecode);
        addVec(6'b000000, 6'b101010, 0, 4'd6, eExec(3'b111, 0));
        addVec(6'b000000, 6'b101010, 0, 4'd7, eAluWb);
        addVec(6'b000000, 6'b100100, 0, 4'd0, eFetch);
        addVec(6'b000000, 6'b100100, 0, 4'd1, eDecode);
        addVec(6'b000000, 6'b100100, 0, 4'd6, eExec(3'b000, 0));
        addVec(6'b000000, 6'b100100, 0, 4'd7, eAluWb);
        addVec(6'b000000, 6'b100101, 0, 4'd0, eFetch);
        addVec(6'b000000, 6'b100101, 0, 4'd1, eDecode);
        addVec(6'b000000, 6'b100101, 0, 4'd6, eExec(3'b001, 0));
        addVec(6'b000000, 6'b100101, 0, 4'd7, eAluWb);
        addVec(6'b000000, 6'b111111, 0, 4'd0, eFetch);
        addVec(6'b000000, 6'b111111, 0, 4'd1, eDecode);
        addVec(6'b000000, 6'b111111, 0, 4'd6, eExec(3'b010, 1));
        addVec(6'b000000, 6'b111111, 0, 4'd7, eAluWb);
        // beq taken, then not taken
        addVec(6'b000100, 6'b000000, 1, 4'd0, eFetch);
        addVec(6'b000100, 6'b000000, 1, 4'd1, eDecode);
        addVec(6'b000100, 6'b000000, 1, 4'd8, eBeq1);
        addVec(6'b000100, 6'b000000, 0, 4'd0, eFetch);
        addVec(6'b000100, 6'b000000, 0, 4'd1, eDecode);
        addVec(6'b000100, 6'b000000, 0, 4'd8, eBeq0);
        // addi
        addVec(6'b001000, 6'b000000, 0, 4'd0, eFetch);
        addVec(6'b001000, 6'b000000, 0, 4'd1, eDecode);
        addVec(6'b001000, 6'b000000, 0, 4'd9, eMemAdr);
        addVec(6'b001000, 6'b000000, 0, 4'd10, eAddiWb);
        // j
        addVec(6'b000010, 6'b000000, 0, 4'd0, eFetch);
        addVec(6'b000010, 6'b000000, 0, 4'd1, eDecode);
        addVec(6'b000010, 6'b000000, 0, 4'd11, eJump);
        // illegal opcode: 2 cycles
        addVec(6'b111111, 6'b000000, 0, 4'd0, eFetch);
        addVec(6'b111111, 6'b000000, 0, 4'd1, eDecodeIll);
        addVec(6'b100011, 6'b000000, 0, 4'd0, eFetch);

        // Reset values while rst_n is held low
        applyStimulus(6'b000000, 6'b000000, 1'b0);
        rst_n = 1'b0;
        #2;
        checkOutput("reset state", {13'b0, state}, 17'd0);
        checkOutput("reset outputs", actBundle, eFetch);
        @(negedge clk);
        checkOutput("reset state held", {13'b0, state}, 17'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].fn, vecs[i].z);
            #1;
            checkOutput($sformatf("vec%0d state", i), {13'b0, state}, {13'b0, vecs[i].st});
            checkOutput($sformatf("vec%0d outputs", i), actBundle, vecs[i].exp);
            @(negedge clk);
        end

        // zero change inside BEQ reaches PCEn within the same cycle
        doReset(6'b000100);
        @(negedge clk);
        @(negedge clk);
        checkOutput("beq state", {13'b0, state}, 17'd8);
        zero = 1'b0;
        #1;
        checkOutput("beq pcen z0", {16'b0, PCEn}, 17'd0);
        zero = 1'b1;
        #1;
        checkOutput("beq pcen z1", {16'b0, PCEn}, 17'd1);
        checkOutput("beq pcsrc", {15'b0, PCSrc}, 17'd1);
        @(negedge clk);
        checkOutput("beq return", {13'b0, state}, 17'd0);

        // Reset mid-MEMRD aborts the lw without a later register write
        doReset(6'b100011);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("abort pre state", {13'b0, state}, 17'd3);
        rst_n = 1'b0;
        #1;
        checkOutput("abort state", {13'b0, state}, 17'd0);
        checkOutput("abort regwrite", {16'b0, RegWrite}, 17'd0);
        @(negedge clk);
        checkOutput("abort held state", {13'b0, state}, 17'd0);
        checkOutput("abort held regwrite", {16'b0, RegWrite}, 17'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput($sformatf("refetch%0d state", k), {13'b0, state}, 17'(k));
            checkOutput($sformatf("refetch%0d regwrite", k), {16'b0, RegWrite}, 17'd0);
            @(negedge clk);
        end
        #1;
        checkOutput("refetch writeback state", {13'b0, state}, 17'd4);
        checkOutput("refetch writeback regwrite", {16'b0, RegWrite}, 17'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style sequencing controller for the multicycle variant of the MIPS core: one shared memory, instruction/data registers and a single ALU reused across cycles. Decodes `Opcode`/`Funct` latched in the instruction register and steps a 12-state FSM. Each cycle it drives the mux selects, register enables and ALU operation for the datapath. It replaces the combinational single-cycle control unit and sits beside the multicycle datapath inside the core top.

## Interface
- Parameters: none.
- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `Opcode`  in  6  `Instr[31:26]` from the instruction register.
- `Funct`  in  6  `Instr[5:0]` from the instruction register.
- `zero`  in  1  ALU zero flag.
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `MemWrite`  out  1  memory write strobe.
- `IRWrite`  out  1  instruction register load.
- `PCEn`  out  1  PC load: `PCWrite | (Branch & zero)`.
- `PCSrc`  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `ALUSrcA`  out  1  0 = PC, 1 = register A.
- `ALUSrcB`  out  2  00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `ALUControl`  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- `RegDst`  out  1  0 = rt, 1 = rd.
- `MemtoReg`  out  1  0 = ALUOut, 1 = Data register.
- `RegWrite`  out  1  register-file write enable.
- `instr_done`  out  1  one-cycle pulse in the final cycle of each instruction.
- `illegal`  out  1  one-cycle pulse on an unsupported opcode or funct.
- `state`  out  4  current state encoding, for debug.

## Operation
- States and encodings:
  - FETCH = 0: `IRWrite`, PC+4, `PCWrite`. Next: DECODE.
  - DECODE = 1: ALU computes PC + (SignImm<<2). Next by opcode:
    - lw (100011) or sw (101011) → MEMADR.
    - R-type (000000) → EXECUTE.
    - beq (000100) → BEQ.
    - addi (001000) → ADDIEX.
    - j (000010) → JUMP.
    - any other opcode → FETCH, with `illegal` = `instr_done` = 1 in DECODE.
  - MEMADR = 2: A + SignImm. Next: lw → MEMRD, sw → MEMWR.
  - MEMRD = 3: `IorD` = 1. Next: MEMWB.
  - MEMWB = 4: `RegDst` = 0, `MemtoReg` = 1, `RegWrite`, done.
  - MEMWR = 5: `IorD` = 1, `MemWrite`, done.
  - EXECUTE = 6: A op B, with the op from `Funct`. Next: ALUWB.
  - ALUWB = 7: `RegDst` = 1, `MemtoReg` = 0, `RegWrite`, done.
  - BEQ = 8: A − B, `PCSrc` = 01, Branch. `PCEn` = `zero`. Done.
  - ADDIEX = 9: A + SignImm. Next: ADDIWB.
  - ADDIWB = 10: `RegDst` = 0, `MemtoReg` = 0, `RegWrite`, done.
  - JUMP = 11: `PCSrc` = 10, `PCWrite`, done.
- All done states return to FETCH.
- Funct map: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Any other funct in EXECUTE gives `ALUControl` = 010 and pulses `illegal`; ALUWB still writes.
- Every output not listed for a state is 0; `ALUControl` defaults to 010.
- Encodings 12–15 are unreachable; if entered, all outputs are 0 and the next state is FETCH.
- Only `PCEn` (through `zero`), DECODE's `illegal`/`instr_done` (through `Opcode`) and EXECUTE's `ALUControl`/`illegal` (through `Funct`) are combinational on inputs. All other outputs decode purely from `state`.

## Timing
- Reset: `state` = FETCH (0) asynchronously while `rst_n` = 0. Outputs hold FETCH values: `IRWrite` = `PCEn` = 1, `ALUSrcB` = 01, `ALUControl` = 010, all others 0. The datapath registers are in reset at the same time, so these enables have no effect.
- The first post-reset FETCH is the cycle after `rst_n` rises. Reset asserted mid-instruction aborts it, with no partial write issued after the reset edge.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- `Opcode`/`Funct` are sampled only in DECODE/MEMADR/EXECUTE. The IR is stable there because `IRWrite` is 1 only in FETCH.
- A `zero` change in BEQ propagates to `PCEn` in the same cycle.

## Structure
- Package `mips_pkg` holds:
  - opcode and funct constants;
  - the 4-bit state enum;
  - ALUControl codes;
  - `PCSrc`/`ALUSrcB` select codes.
- Sub-module `alu_decoder` maps a 2-bit ALUOp (00 add, 01 sub, 10 funct) plus `Funct` to `ALUControl` and a funct-illegal flag.
- The FSM drives ALUOp per state.

## Test plan
- Reset, then lw (opcode 100011): `state` sequence 0,1,2,3,4,0. `RegWrite` and `MemtoReg` = 1 only in state 4; `instr_done` high exactly 1 cycle.
- sw: `MemWrite` = 1 and `IorD` = 1 only in state 5; `RegWrite` never asserted; 4 cycles.
- R-type with funct 100010 then 101010: `ALUControl` = 110 then 111 in EXECUTE; `RegDst` = 1 in ALUWB.
- beq with `zero` = 1: `PCEn` = 1 in state 8 with `PCSrc` = 01. With `zero` = 0: `PCEn` = 0. 3 cycles each.
- j: `PCSrc` = 10 and `PCEn` = 1 in state 11. Opcode 111111: `illegal` and `instr_done` pulse in DECODE, back to FETCH after 2 cycles.
- Drop `rst_n` during MEMRD: `state` = 0 immediately. No `RegWrite` is asserted afterwards until a new instruction is fetched.
